fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised instruction prefetcher for the fetch stage. Issues word-aligned reads to a
//  pipelined iMEM (separate grant and response phases, in-order responses, up to MAX_OUTSTANDING
//  reads in flight) and queues returned words, with their addresses, in a FIFO_DEPTH-entry FIFO.
//  Sits between iMEM and the realign buffer/decompressor; on a branch/jump it flushes the queue
//  and silently discards stale in-flight responses.
// PARAMETERS
//  BOOT_ADDRESS     32'h0  first fetch address after reset (word aligned)
//  FIFO_DEPTH       4      queued words, power of two, >=2
//  MAX_OUTSTANDING  2      max granted-but-unanswered reads, 1..FIFO_DEPTH
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async reset, active low
//  req_i            in   1   fetch enable from later stages
//  target_valid_i   in   1   redirect strobe (flush)
//  target_addr_i    in   32  redirect address; bits [1:0] ignored
//  instr_valid_o    out  1   FIFO head valid
//  instr_ready_i    in   1   consumer pops head when valid&ready
//  instr_o          out  32  head word
//  instr_addr_o     out  32  head word address
//  imem_valid_o     out  1   read request
//  imem_ready_i     in   1   request granted this cycle
//  imem_addr_o      out  32  request address, always [1:0]=0
//  imem_rvalid_i    in   1   response valid (in order, >=1 cycle after grant)
//  imem_rdata_i     in   32  response data
// BEHAVIOUR
//  Reset: fetch_addr=BOOT_ADDRESS, resp_addr=BOOT_ADDRESS, FIFO empty, outstanding=0, discard=0;
//   instr_valid_o=0, instr_o=0, instr_addr_o=0, imem_valid_o=0 (also gated by rst_n).
//  Credit: live = outstanding - discard. Issue allowed when outstanding < MAX_OUTSTANDING
//   and fifo_count + live < FIFO_DEPTH, so a granted response always has a FIFO slot.
//  imem_valid_o = rst_n & (req_i | target_valid_i) & credit (in the flush cycle credit uses
//   fifo_count=0, live=0); imem_addr_o = target_valid_i ? {target_addr_i[31:2],2'b00} : fetch_addr.
//  Grant (valid&ready): fetch_addr <= imem_addr_o+4; outstanding++. Wrap at 2^32 is modulo.
//  Response: outstanding--. If discard>0: drop word, discard--. Else push {imem_rdata_i,resp_addr},
//   resp_addr += 4.
//  Grant and response in the same cycle: outstanding unchanged.
//  Output: show-ahead FIFO, no bypass; instr_valid_o = FIFO non-empty. Minimum latency is
//   grant@t, rvalid@t+1, instr_valid_o@t+2.
//   Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle is legal at any occupancy.
//  Flush (target_valid_i=1): FIFO cleared (any pop/push that cycle ignored);
//   resp_addr <= target aligned; fetch_addr <= target+4 if granted, else target;
//   discard <= outstanding - imem_rvalid_i (stale reads only). A same-cycle grant is live, not discarded.
//   Back-to-back flushes are legal; each recomputes discard from the current outstanding.
//  req_i=0: no new requests. Outstanding responses are still accepted and queued.
//  Overflow is impossible by credit. An assertion flags a push into a full FIFO and
//   imem_rvalid_i with outstanding=0.
//  Reset mid-operation: all state returns to reset values immediately; post-reset responses
//   from pre-reset grants are a bench error and are not required to be handled.
// TESTING
//  1 Reset, req_i=1, mem grant=1, latency 1 -> addrs 0,4,8.. ; instr_valid_o first @cycle 3,
//    instr_addr_o 0x0,0x4,0x8 in order.
//  2 instr_ready_i=0, DEPTH=4 -> exactly 4 words queued, imem_valid_o low; release ready -> refill resumes.
//  3 Latency 3, MAX_OUTSTANDING=2, flush to 0x103 with 2 in flight -> both stale dropped,
//    first valid output addr 0x100.
//  4 Flush on cycle with rvalid=1 and grant=1 -> discard=outstanding-1, granted 0x100 word delivered.
//  5 Pop+push same cycle at FIFO full-1 and full, req_i toggling -> no loss, no duplication,
//    addresses contiguous.
//  6 Async rst_n low mid-burst -> all outputs 0 immediately; refetch from BOOT_ADDRESS.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: issues word-aligned reads to a pipelined iMEM and queues the
// returned words with their addresses; a redirect flushes the queue and drops stale responses.
module fetch_prefetch_queue #(
  parameter logic [31:0] BOOT_ADDRESS    = 32'h0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        target_valid_i,
  input  logic [31:0] target_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        imem_valid_o,
  input  logic        imem_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, resp_addr_q, resp_addr_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d, live;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   target_al;
  logic          credit, grant, push, pop, flush;
  logic          unused_ok;

  assign unused_ok = ^target_addr_i[1:0];
  assign target_al = {target_addr_i[31:2], 2'b00};
  assign flush     = target_valid_i;
  assign live      = outst_q - discard_q;

  // A granted read must always find a FIFO slot, counting queued words and live reads.
  // On a redirect the queue and all current reads are about to become stale.
  always_comb begin
    credit = 1'b0;
    if (outst_q < OW'(MAX_OUTSTANDING)) begin
      if (flush) credit = 1'b1;
      else       credit = (32'(count_q) + 32'(live)) < 32'(FIFO_DEPTH);
    end
  end

  assign imem_valid_o  = rst_n & (req_i | target_valid_i) & credit;
  assign imem_addr_o   = flush ? target_al : fetch_addr_q;
  assign grant         = imem_valid_o & imem_ready_i;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? mem_q[rd_ptr_q].data : 32'h0;
  assign instr_addr_o  = instr_valid_o ? mem_q[rd_ptr_q].addr : 32'h0;
  assign push          = imem_rvalid_i & (discard_q == '0) & ~flush;
  assign pop           = instr_valid_o & instr_ready_i & ~flush;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (grant)      fetch_addr_d = imem_addr_o + 32'd4;
    else if (flush) fetch_addr_d = target_al;

    outst_d = outst_q + OW'(grant) - OW'(imem_rvalid_i);

    // A read granted in the redirect cycle targets the new stream, so it is not discarded.
    discard_d = discard_q;
    if (flush)                                    discard_d = outst_q - OW'(imem_rvalid_i);
    else if (imem_rvalid_i && discard_q != '0)    discard_d = discard_q - OW'(1);

    resp_addr_d = resp_addr_q;
    if (flush)     resp_addr_d = target_al;
    else if (push) resp_addr_d = resp_addr_q + 32'd4;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{data: imem_rdata_i, addr: resp_addr_q};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= BOOT_ADDRESS;
      resp_addr_q  <= BOOT_ADDRESS;
      outst_q      <= '0;
      discard_q    <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      mem_q        <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_q        <= mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == CW'(FIFO_DEPTH)));
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid_i && outst_q == '0));
endmodule
